// File: rtl/ddr_dma_pkg.sv
// Shared types and constants for the DDR line-copy DMA (ddr_soc_dma and its watchdog).
package ddr_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_CMD,
        ST_WAIT,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam int   CMD_OP_BIT     = 31;
    localparam logic CMD_OP_STORE   = 1'b1;
    localparam logic CMD_OP_LOAD    = 1'b0;
    localparam int   DDR_ADDR_WIDTH = 26;
    localparam int   BUF_WORDS      = 4;

    // Command word: op in the top bit, zero-extended line address below it.
    function automatic logic [31:0] make_cmd(input logic op, input logic [30:0] addr);
        logic [31:0] c;
        c = {1'b0, addr};
        c[CMD_OP_BIT] = op;
        return c;
    endfunction

endpackage

// File: rtl/ddr_dma_wdog.sv
// Loadable down-counter with expire flag; bounds how long a DDR command may stay outstanding.
module ddr_dma_wdog #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en && count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/ddr_soc_dma.sv
// DMA moving whole 128-bit lines between local SRAM and the DDR command/buffer interface.
// Optional watchdog on outstanding commands: define DDR_DMA_TIMEOUT_EN.
module ddr_soc_dma #(
    parameter int DDR_ADDR_WIDTH = ddr_dma_pkg::DDR_ADDR_WIDTH,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH      = 16,
    parameter int STAT_HOLDOFF   = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      soc_clk,
    input  logic                      soc_rst,
    input  logic                      start,
    input  logic                      dir,
    input  logic [DDR_ADDR_WIDTH-1:0] ddr_base,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_base,
    input  logic [LEN_WIDTH-1:0]      num_lines,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    output logic [31:0]               soc_ddr_cmd,
    output logic                      soc_ddr_cmd_valid,
    input  logic [31:0]               soc_ddr_status,
    output logic [1:0]                soc_ddr_data_buf_idx,
    output logic                      soc_ddr_buf_wr,
    output logic                      soc_ddr_buf_rd,
    output logic [31:0]               soc_ddr_data_in,
    input  logic [31:0]               soc_ddr_data_out
);
    import ddr_dma_pkg::*;

    localparam int HW = $clog2(STAT_HOLDOFF + 2);
    localparam logic [HW-1:0] HOLD_LIM = HW'(STAT_HOLDOFF);
    localparam logic [2:0] CNT_LAST = 3'(BUF_WORDS - 1);
    localparam logic [2:0] CNT_FULL = 3'(BUF_WORDS);

    state_t                    state_reg;
    logic                      dir_reg;
    logic [DDR_ADDR_WIDTH-1:0] ddr_addr_reg;
    logic [MEM_ADDR_WIDTH-1:0] mem_ptr_reg;
    logic [LEN_WIDTH-1:0]      lines_left_reg;
    logic [2:0]                cnt_reg;
    logic [HW-1:0]             hold_reg;
    logic                      busy_reg, done_reg, err_reg;
    logic                      mem_req_reg, mem_we_reg;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_reg;
    logic [31:0]               cmd_reg;
    logic                      cmd_valid_reg, buf_wr_reg, buf_rd_reg;
    logic [1:0]                idx_reg;
    logic                      timeout;

    logic [DDR_ADDR_WIDTH-1:0] ddr_addr_next;
    logic [MEM_ADDR_WIDTH-1:0] mem_ptr_next;
    logic [LEN_WIDTH-1:0]      lines_next;
    logic                      status_ok;

    assign ddr_addr_next = ddr_addr_reg + DDR_ADDR_WIDTH'(1);
    assign mem_ptr_next  = mem_ptr_reg + MEM_ADDR_WIDTH'(BUF_WORDS);
    assign lines_next    = lines_left_reg - LEN_WIDTH'(1);
    assign status_ok     = (hold_reg == HOLD_LIM) && (soc_ddr_status != '0);

`ifdef DDR_DMA_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    ddr_dma_wdog #(.WIDTH(WDW)) u_wdog (
        .clk        (soc_clk),
        .srst       (soc_rst),
        .load       (state_reg == ST_CMD),
        .en         (state_reg == ST_WAIT),
        .load_value (WDW'(TIMEOUT_CYCLES - 1)),
        .expired    (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge soc_clk) begin
        if (soc_rst) begin
            state_reg      <= ST_IDLE;
            dir_reg        <= 1'b0;
            ddr_addr_reg   <= '0;
            mem_ptr_reg    <= '0;
            lines_left_reg <= '0;
            cnt_reg        <= '0;
            hold_reg       <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            cmd_reg        <= '0;
            cmd_valid_reg  <= 1'b0;
            buf_wr_reg     <= 1'b0;
            buf_rd_reg     <= 1'b0;
            idx_reg        <= '0;
        end else begin
            // Outputs describe the coming cycle; strobes default low and states re-assert them.
            done_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            cmd_reg       <= '0;
            cmd_valid_reg <= 1'b0;
            buf_wr_reg    <= 1'b0;
            buf_rd_reg    <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        dir_reg        <= dir;
                        ddr_addr_reg   <= ddr_base;
                        mem_ptr_reg    <= mem_base;
                        lines_left_reg <= num_lines;
                        err_reg        <= 1'b0;
                        cnt_reg        <= '0;
                        if (num_lines == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            busy_reg <= 1'b1;
                            if (dir == CMD_OP_STORE) begin
                                state_reg    <= ST_FILL;
                                mem_req_reg  <= 1'b1;
                                mem_addr_reg <= mem_base;
                            end else begin
                                state_reg     <= ST_CMD;
                                cmd_valid_reg <= 1'b1;
                                cmd_reg       <= make_cmd(CMD_OP_LOAD, 31'(ddr_base));
                            end
                        end
                    end
                end
                ST_FILL: begin
                    // Read k is issued in cycle k; its data lands in buffer word k one cycle later.
                    if (cnt_reg < CNT_LAST) begin
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= mem_ptr_reg + MEM_ADDR_WIDTH'(cnt_reg) + MEM_ADDR_WIDTH'(1);
                    end
                    if (cnt_reg < CNT_FULL) begin
                        buf_wr_reg <= 1'b1;
                        idx_reg    <= cnt_reg[1:0];
                        cnt_reg    <= cnt_reg + 3'd1;
                    end else begin
                        state_reg     <= ST_CMD;
                        cmd_valid_reg <= 1'b1;
                        cmd_reg       <= make_cmd(CMD_OP_STORE, 31'(ddr_addr_reg));
                    end
                end
                ST_CMD: begin
                    state_reg <= ST_WAIT;
                    hold_reg  <= '0;
                end
                ST_WAIT: begin
                    if (hold_reg != HOLD_LIM) begin
                        hold_reg <= hold_reg + HW'(1);
                    end
                    if (status_ok) begin
                        if (dir_reg == CMD_OP_STORE) begin
                            state_reg <= ST_NEXT;
                        end else begin
                            state_reg  <= ST_DRAIN;
                            buf_rd_reg <= 1'b1;
                            idx_reg    <= '0;
                            cnt_reg    <= '0;
                        end
                    end else if (timeout) begin
                        state_reg <= ST_DONE;
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_reg < CNT_LAST) begin
                        buf_rd_reg <= 1'b1;
                        idx_reg    <= cnt_reg[1:0] + 2'd1;
                    end
                    if (cnt_reg < CNT_FULL) begin
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b1;
                        mem_addr_reg <= mem_ptr_reg + MEM_ADDR_WIDTH'(cnt_reg);
                        cnt_reg      <= cnt_reg + 3'd1;
                    end else begin
                        state_reg <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    ddr_addr_reg   <= ddr_addr_next;
                    mem_ptr_reg    <= mem_ptr_next;
                    lines_left_reg <= lines_next;
                    cnt_reg        <= '0;
                    if (lines_next == '0) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (dir_reg == CMD_OP_STORE) begin
                        state_reg    <= ST_FILL;
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= mem_ptr_next;
                    end else begin
                        state_reg     <= ST_CMD;
                        cmd_valid_reg <= 1'b1;
                        cmd_reg       <= make_cmd(CMD_OP_LOAD, 31'(ddr_addr_next));
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy                 = busy_reg;
    assign done                 = done_reg;
    assign err                  = err_reg;
    assign mem_req              = mem_req_reg;
    assign mem_we               = mem_we_reg;
    assign mem_addr             = mem_addr_reg;
    assign soc_ddr_cmd          = cmd_reg;
    assign soc_ddr_cmd_valid    = cmd_valid_reg;
    assign soc_ddr_data_buf_idx = idx_reg;
    assign soc_ddr_buf_wr       = buf_wr_reg;
    assign soc_ddr_buf_rd       = buf_rd_reg;
    // Read data from either side arrives one cycle after the request, exactly when the write strobe is up.
    assign soc_ddr_data_in      = buf_wr_reg ? mem_rdata : '0;
    assign mem_wdata            = mem_we_reg ? soc_ddr_data_out : '0;

endmodule
